mixed_path_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares a single registered output stage of the mixed data/address path. Each requester presents an 8-bit data byte and an 8-bit address under a req/gnt handshake. The block registers the winning word as `{data, 8'h00}` with its address, and holds it under an out_valid/out_ready handshake toward the downstream consumer. It also keeps a wrapping count of completed downstream transfers for status readback.

---
 rtl/mixed_path_arbiter_if.sv | 39 +++
 rtl/mixed_path_arbiter.sv | 82 ++++++++
 tb/tb_mixed_path_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mixed_path_arbiter_if.sv
// mixed_path_arbiter_if
//   Bundles the two requester channels (req/data/addr/gnt), the registered
//   output channel (data_out/addr_out/out_src under out_valid/out_ready) and
//   the status outputs (xfer_cnt, busy) of the mixed-path arbiter.
//   Modports:
//     slave  - the arbiter: takes requests and out_ready, drives grants,
//              the held output word and status.
//     master - the surrounding logic: requesters plus downstream consumer.
interface mixed_path_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic                req0;
  logic [DATA_W-1:0]   data0;
  logic [ADDR_W-1:0]   addr0;
  logic                gnt0;
  logic                req1;
  logic [DATA_W-1:0]   data1;
  logic [ADDR_W-1:0]   addr1;
  logic                gnt1;
  logic [2*DATA_W-1:0] data_out;
  logic [ADDR_W-1:0]   addr_out;
  logic                out_src;
  logic                out_valid;
  logic                out_ready;
  logic [CNT_W-1:0]    xfer_cnt;
  logic                busy;

  modport slave (
    input  req0, data0, addr0, req1, data1, addr1, out_ready,
    output gnt0, gnt1, data_out, addr_out, out_src, out_valid, xfer_cnt, busy
  );

  modport master (
    output req0, data0, addr0, req1, data1, addr1, out_ready,
    input  gnt0, gnt1, data_out, addr_out, out_src, out_valid, xfer_cnt, busy
  );
endinterface

// File: rtl/mixed_path_arbiter.sv
// mixed_path_arbiter
//   Two-requester round-robin arbiter feeding one registered output stage.
//   The winning byte is widened to {data, zeros} and held with its address
//   and source index until the downstream consumer takes it. A wrapping
//   counter tracks completed downstream transfers.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high reset
//     bus   - mixed_path_arbiter_if.slave: req/data/addr/gnt per requester,
//             data_out/addr_out/out_src/out_valid/out_ready, xfer_cnt, busy
module mixed_path_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mixed_path_arbiter_if.slave   bus
);

  function automatic logic [2*DATA_W-1:0] widen_word(input logic [DATA_W-1:0] d);
    return {d, {DATA_W{1'b0}}};
  endfunction

  logic                tie_p0;
  logic                win_p0;
  logic                load_p0;
  logic                drain_p0;
  logic [2*DATA_W-1:0] data_p1;
  logic [ADDR_W-1:0]   addr_p1;
  logic                src_p1;
  logic                vld_p1;
  logic                last_q;
  logic [CNT_W-1:0]    cnt_q;

  // ---- Stage 0: combinational arbitration --------------------------------
  always_comb begin
    tie_p0   = bus.req0 & bus.req1;
    // On a tie the requester that did not win last time goes next; with a
    // single request, req1 alone decides the winner index.
    win_p0   = tie_p0 ? ~last_q : bus.req1;
    // The output register can take a word when empty or being drained now.
    load_p0  = (bus.req0 | bus.req1) & (~vld_p1 | bus.out_ready) & ~reset;
    drain_p0 = vld_p1 & bus.out_ready;
  end

  assign bus.gnt0 = load_p0 & ~win_p0;
  assign bus.gnt1 = load_p0 &  win_p0;

  // ---- Stage 1: output register, pointer and transfer counter ------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_p1 <= '0;
      addr_p1 <= '0;
      src_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      if (load_p0) begin
        data_p1 <= widen_word(win_p0 ? bus.data1 : bus.data0);
        addr_p1 <= win_p0 ? bus.addr1 : bus.addr0;
        src_p1  <= win_p0;
        last_q  <= win_p0;
        vld_p1  <= 1'b1;
      end else if (drain_p0) begin
        vld_p1  <= 1'b0;
      end
      if (drain_p0) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.data_out  = data_p1;
  assign bus.addr_out  = addr_p1;
  assign bus.out_src   = src_p1;
  assign bus.out_valid = vld_p1;
  assign bus.xfer_cnt  = cnt_q;
  assign bus.busy      = vld_p1 | bus.req0 | bus.req1;

endmodule

// File: tb/tb_mixed_path_arbiter.sv
// tb_mixed_path_arbiter
//   Directed bench for mixed_path_arbiter. The counter is built 4 bits wide
//   so that the wrap from 15 to 0 is reached in a few cycles.
module tb_mixed_path_arbiter;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  mixed_path_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  mixed_path_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.req0 = 1'b0; bus.data0 = '0; bus.addr0 = '0;
    bus.req1 = 1'b0; bus.data1 = '0; bus.addr1 = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = '0;
    #1;
  endtask

  task automatic test_reset;
    clear_inputs();
    bus.req0 = 1'b1;
    reset = 1'b1;
    #1;
    n_tests++; if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_forced: got %b want 0", bus.gnt0); end
    tick();
    reset = 1'b0;
    bus.req0 = 1'b0;
    exp_cnt = '0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_data_out: got %h want 0000", bus.data_out); end
    n_tests++; if (bus.xfer_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_xfer_cnt: got %0d want 0", bus.xfer_cnt); end
    n_tests++; if ({bus.gnt0, bus.gnt1} !== 2'b00) begin n_fail++; $display("FAIL reset_idle_gnt: got %b want 00", {bus.gnt0, bus.gnt1}); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_single;
    bus.req0 = 1'b1; bus.data0 = 8'hA5; bus.addr0 = 8'h3C; bus.out_ready = 1'b1;
    #1;
    n_tests++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin n_fail++; $display("FAIL single_gnt: got %b want 10", {bus.gnt0, bus.gnt1}); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    tick();
    bus.req0 = 1'b0;
    n_tests++; if (bus.data_out !== 16'hA500) begin n_fail++; $display("FAIL single_data_out: got %h want A500", bus.data_out); end
    n_tests++; if (bus.addr_out !== 8'h3C) begin n_fail++; $display("FAIL single_addr_out: got %h want 3C", bus.addr_out); end
    n_tests++; if (bus.out_src !== 1'b0) begin n_fail++; $display("FAIL single_out_src: got %b want 0", bus.out_src); end
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b want 1", bus.out_valid); end
    n_tests++; if (bus.xfer_cnt !== 4'd0) begin n_fail++; $display("FAIL single_cnt_before: got %0d want 0", bus.xfer_cnt); end
    tick();
    exp_cnt = 4'd1;
    n_tests++; if (bus.xfer_cnt !== 4'd1) begin n_fail++; $display("FAIL single_cnt_after: got %0d want 1", bus.xfer_cnt); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_round_robin;
    logic [15:0] exp_data;
    logic [7:0]  exp_addr;
    do_reset();
    bus.req0 = 1'b1; bus.data0 = 8'h11; bus.addr0 = 8'h10;
    bus.req1 = 1'b1; bus.data1 = 8'h22; bus.addr1 = 8'h20;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_tests++; if ({bus.gnt0, bus.gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b", k, {bus.gnt0, bus.gnt1}); end
      tick();
      if (k > 0) exp_cnt = exp_cnt + 1'b1;
      exp_data = (k % 2 == 0) ? 16'h1100 : 16'h2200;
      exp_addr = (k % 2 == 0) ? 8'h10 : 8'h20;
      n_tests++; if (bus.out_src !== ((k % 2 == 0) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL rr_out_src[%0d]: got %b want %0d", k, bus.out_src, k % 2); end
      n_tests++; if (bus.data_out !== exp_data || bus.addr_out !== exp_addr) begin n_fail++; $display("FAIL rr_word[%0d]: got %h/%h want %h/%h", k, bus.data_out, bus.addr_out, exp_data, exp_addr); end
      n_tests++; if (bus.xfer_cnt !== exp_cnt) begin n_fail++; $display("FAIL rr_cnt[%0d]: got %0d want %0d", k, bus.xfer_cnt, exp_cnt); end
    end
    n_tests++; if (bus.xfer_cnt !== 4'd5) begin n_fail++; $display("FAIL rr_cnt_after6: got %0d want 5", bus.xfer_cnt); end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    exp_cnt = exp_cnt + 1'b1;
    n_tests++; if (bus.xfer_cnt !== 4'd6) begin n_fail++; $display("FAIL rr_cnt_final: got %0d want 6", bus.xfer_cnt); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure;
    bus.req0 = 1'b1; bus.data0 = 8'h5A; bus.addr0 = 8'h5B; bus.out_ready = 1'b1;
    #1;
    n_tests++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin n_fail++; $display("FAIL bp_load_gnt: got %b want 10", {bus.gnt0, bus.gnt1}); end
    tick();
    bus.req0 = 1'b0; bus.out_ready = 1'b0;
    bus.req1 = 1'b1; bus.data1 = 8'hC3; bus.addr1 = 8'h77;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_tests++; if ({bus.gnt0, bus.gnt1} !== 2'b00) begin n_fail++; $display("FAIL bp_hold_gnt[%0d]: got %b want 00", k, {bus.gnt0, bus.gnt1}); end
      tick();
      n_tests++; if (bus.data_out !== 16'h5A00 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_word[%0d]: got %h v%b want 5A00 v1", k, bus.data_out, bus.out_valid); end
      n_tests++; if (bus.xfer_cnt !== exp_cnt) begin n_fail++; $display("FAIL bp_hold_cnt[%0d]: got %0d want %0d", k, bus.xfer_cnt, exp_cnt); end
    end
    bus.out_ready = 1'b1;
    #1;
    n_tests++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin n_fail++; $display("FAIL bp_resume_gnt: got %b want 01", {bus.gnt0, bus.gnt1}); end
    tick();
    bus.req1 = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    n_tests++; if (bus.data_out !== 16'hC300 || bus.addr_out !== 8'h77 || bus.out_src !== 1'b1) begin n_fail++; $display("FAIL bp_new_word: got %h/%h/%b want C300/77/1", bus.data_out, bus.addr_out, bus.out_src); end
    n_tests++; if (bus.xfer_cnt !== exp_cnt) begin n_fail++; $display("FAIL bp_cnt: got %0d want %0d", bus.xfer_cnt, exp_cnt); end
    tick();
    exp_cnt = exp_cnt + 1'b1;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.xfer_cnt !== exp_cnt) begin n_fail++; $display("FAIL bp_drain: got v%b cnt %0d want v0 cnt %0d", bus.out_valid, bus.xfer_cnt, exp_cnt); end
  endtask

  task automatic test_withdraw;
    // Load from requester 0 so the pointer says "0 won last".
    bus.req0 = 1'b1; bus.data0 = 8'h44; bus.addr0 = 8'h40; bus.out_ready = 1'b1;
    tick();
    bus.req0 = 1'b0; bus.out_ready = 1'b0;
    bus.req1 = 1'b1; bus.data1 = 8'h99; bus.addr1 = 8'h90;
    #1;
    n_tests++; if (bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL wd_no_gnt1: got %b want 0", bus.gnt1); end
    tick();
    bus.req1 = 1'b0;
    #1;
    n_tests++; if ({bus.gnt0, bus.gnt1} !== 2'b00) begin n_fail++; $display("FAIL wd_dropped_gnt: got %b want 00", {bus.gnt0, bus.gnt1}); end
    tick();
    n_tests++; if (bus.data_out !== 16'h4400 || bus.out_src !== 1'b0) begin n_fail++; $display("FAIL wd_held: got %h/%b want 4400/0", bus.data_out, bus.out_src); end
    bus.req0 = 1'b1; bus.data0 = 8'h66; bus.req1 = 1'b1; bus.out_ready = 1'b1;
    #1;
    n_tests++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin n_fail++; $display("FAIL wd_tie_gnt: got %b want 01", {bus.gnt0, bus.gnt1}); end
    tick();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    n_tests++; if (bus.out_src !== 1'b1 || bus.data_out !== 16'h9900) begin n_fail++; $display("FAIL wd_tie_word: got %b/%h want 1/9900", bus.out_src, bus.data_out); end
    n_tests++; if (bus.xfer_cnt !== exp_cnt) begin n_fail++; $display("FAIL wd_cnt: got %0d want %0d", bus.xfer_cnt, exp_cnt); end
    tick();
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic test_wrap;
    logic exp_vld;
    exp_vld = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 8'h01; bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.data0 = 8'(i);
      tick();
      if (exp_vld) exp_cnt = exp_cnt + 1'b1;
      exp_vld = 1'b1;
      n_tests++; if (bus.xfer_cnt !== exp_cnt) begin n_fail++; $display("FAIL wrap_cnt[%0d]: got %0d want %0d", i, bus.xfer_cnt, exp_cnt); end
    end
    bus.req0 = 1'b0;
    tick();
    exp_cnt = exp_cnt + 1'b1;
    n_tests++; if (bus.xfer_cnt !== exp_cnt || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_final: got cnt %0d v%b want cnt %0d v0", bus.xfer_cnt, bus.out_valid, exp_cnt); end
  endtask

  task automatic test_async_reset;
    bus.req0 = 1'b1; bus.data0 = 8'hE7; bus.addr0 = 8'hE0; bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    n_tests++; if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL ar_bp_gnt0: got %b want 0", bus.gnt0); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b1 || bus.data_out !== 16'hE700) begin n_fail++; $display("FAIL ar_held: got v%b %h want v1 E700", bus.out_valid, bus.data_out); end
    #2;
    reset = 1'b1;
    #1;
    exp_cnt = '0;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.data_out !== 16'h0000 || bus.addr_out !== 8'h00) begin n_fail++; $display("FAIL ar_clear_word: got v%b %h/%h want v0 0000/00", bus.out_valid, bus.data_out, bus.addr_out); end
    n_tests++; if (bus.xfer_cnt !== 4'd0) begin n_fail++; $display("FAIL ar_clear_cnt: got %0d want 0", bus.xfer_cnt); end
    n_tests++; if ({bus.gnt0, bus.gnt1} !== 2'b00) begin n_fail++; $display("FAIL ar_gnt_forced: got %b want 00", {bus.gnt0, bus.gnt1}); end
    reset = 1'b0;
    bus.req1 = 1'b1; bus.data1 = 8'h3D; bus.out_ready = 1'b1;
    #1;
    n_tests++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin n_fail++; $display("FAIL ar_first_tie: got %b want 10", {bus.gnt0, bus.gnt1}); end
    tick();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    n_tests++; if (bus.out_src !== 1'b0 || bus.data_out !== 16'hE700) begin n_fail++; $display("FAIL ar_first_word: got %b/%h want 0/E700", bus.out_src, bus.data_out); end
    n_tests++; if (bus.xfer_cnt !== 4'd0) begin n_fail++; $display("FAIL ar_cnt_after: got %0d want 0", bus.xfer_cnt); end
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_withdraw();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
